fwd_hazard_unit: RTL and testbench

//  Parametrised operand-forwarding and interlock unit for the NPC pipeline, sitting beside ID.

---
 rtl/hazard_pkg.sv | 52 +++++
 rtl/reg_scoreboard.sv | 28 ++
 rtl/fwd_hazard_unit.sv | 137 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and the per-read-port bypass/interlock selector for fwd_hazard_unit.
package hazard_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {SRC_NONE, SRC_EX, SRC_MEM, SRC_WB, SRC_LU} fwd_src_e;
    typedef enum logic [1:0] {STALL_NONE, STALL_LOAD_USE, STALL_SCOREBOARD} stall_cause_e;

    typedef struct packed {
        fwd_src_e src;
        logic     ld_stall;
        logic     sb_stall;
    } port_sel_t;

    // Youngest producer wins; a not-yet-valid EX/MEM match stalls without looking further back.
    function automatic port_sel_t port_select(
        input logic              active,
        input logic [REG_AW-1:0] r,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_waddr,
        input logic              ex_dvalid,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_waddr,
        input logic              mem_dvalid,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_waddr,
        input logic              lu_done,
        input logic [REG_AW-1:0] lu_waddr,
        input logic              busy_r
    );
        port_sel_t s;
        s = '{src: SRC_NONE, ld_stall: 1'b0, sb_stall: 1'b0};
        if (active) begin
            if (ex_we && ex_waddr == r) begin
                if (ex_dvalid) s.src = SRC_EX;
                else           s.ld_stall = 1'b1;
            end else if (mem_we && mem_waddr == r) begin
                if (mem_dvalid) s.src = SRC_MEM;
                else            s.ld_stall = 1'b1;
            end else if (wb_we && wb_waddr == r) begin
                s.src = SRC_WB;
            end else if (lu_done && lu_waddr == r) begin
                s.src = SRC_LU;
            end else if (busy_r) begin
                s.sb_stall = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for outstanding long-latency ops; x0 never busy.
module reg_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [4:0]      set_addr,
    input  logic            clr_en,
    input  logic [4:0]      clr_addr,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-cycle reissue to the retiring reg stays busy.
    always_comb begin
        busy_d = busy;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_d;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, LU scoreboard interlock and deadlock watchdog beside ID.
// Optional stall perf counters enabled by macro FWD_HAZARD_PERF_EN.
module fwd_hazard_unit #(
    parameter int XLEN        = 64,
    parameter int NREG        = 32,
    parameter int STALL_LIMIT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    input  logic            re1,
    input  logic            re2,
    input  logic            id_we,
    input  logic [4:0]      id_waddr,
    input  logic            id_lu,
    input  logic            ex_we,
    input  logic [4:0]      ex_waddr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_dvalid,
    input  logic            mem_we,
    input  logic [4:0]      mem_waddr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_dvalid,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            lu_done,
    input  logic [4:0]      lu_waddr,
    input  logic [XLEN-1:0] lu_wdata,
    output logic            fwd_a,
    output logic            fwd_b,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic            id_fire,
    output logic [NREG-1:0] busy,
    output logic            deadlock,
    output logic [31:0]     ld_stall_cnt,
    output logic [31:0]     sb_stall_cnt
);
    import hazard_pkg::*;

    localparam int CW = $clog2(STALL_LIMIT + 1);

    logic [NREG-1:0]             busy_q;
    logic [1:0][REG_AW-1:0]      rd_addr;
    logic [1:0]                  rd_en;
    port_sel_t [1:0]             sel;
    logic [1:0][XLEN-1:0]        src;
    logic                        waw_stall, ld_any, sb_any;
    logic [CW-1:0]               stall_cnt;

    assign rd_addr = {raddr2, raddr1};
    assign rd_en   = {re2, re1};

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign sel[p] = port_select(id_valid & rd_en[p] & (rd_addr[p] != '0), rd_addr[p],
                                    ex_we, ex_waddr, ex_dvalid,
                                    mem_we, mem_waddr, mem_dvalid,
                                    wb_we, wb_waddr,
                                    lu_done, lu_waddr, busy_q[rd_addr[p]]);
        always_comb begin
            src[p] = '0;
            case (sel[p].src)
                SRC_EX:  src[p] = ex_data;
                SRC_MEM: src[p] = mem_data;
                SRC_WB:  src[p] = wb_data;
                SRC_LU:  src[p] = lu_wdata;
                default: src[p] = '0;
            endcase
        end
    end

    assign fwd_a = (sel[0].src != SRC_NONE);
    assign fwd_b = (sel[1].src != SRC_NONE);
    assign src_a = src[0];
    assign src_b = src[1];

    // Writing a reg still owed by the LU would let the late LU result clobber it.
    assign waw_stall = id_we & (id_waddr != '0) & busy_q[id_waddr]
                     & ~(lu_done & (lu_waddr == id_waddr));
    assign ld_any  = sel[0].ld_stall | sel[1].ld_stall;
    assign sb_any  = sel[0].sb_stall | sel[1].sb_stall | waw_stall;
    assign stall   = ld_any | sb_any;
    assign id_fire = id_valid & ~stall;

    reg_scoreboard #(.NREG(NREG)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (id_fire & id_lu & id_we),
        .set_addr (id_waddr),
        .clr_en   (lu_done),
        .clr_addr (lu_waddr),
        .busy     (busy_q)
    );
    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            deadlock  <= 1'b0;
        end else begin
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != CW'(STALL_LIMIT))
                stall_cnt <= stall_cnt + 1'b1;
            if (stall && stall_cnt == CW'(STALL_LIMIT - 1))
                deadlock <= 1'b1;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    stall_cause_e cause;
    logic [31:0]  ld_q, sb_q;

    // A cycle with both causes is attributed to load-use only.
    assign cause = ld_any ? STALL_LOAD_USE : (sb_any ? STALL_SCOREBOARD : STALL_NONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_q <= '0;
            sb_q <= '0;
        end else begin
            if (cause == STALL_LOAD_USE)   ld_q <= ld_q + 32'd1;
            if (cause == STALL_SCOREBOARD) sb_q <= sb_q + 32'd1;
        end
    end
    assign ld_stall_cnt = ld_q;
    assign sb_stall_cnt = sb_q;
`else
    assign ld_stall_cnt = '0;
    assign sb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with expectation queue and perf-counter model.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, re1, re2, id_we, id_lu;
    logic [4:0]  raddr1, raddr2, id_waddr;
    logic        ex_we, ex_dvalid, mem_we, mem_dvalid, wb_we, lu_done;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr, lu_waddr;
    logic [63:0] ex_data, mem_data, wb_data, lu_wdata;
    logic        fwd_a, fwd_b, stall, id_fire, deadlock;
    logic [63:0] src_a, src_b;
    logic [31:0] busy, ld_stall_cnt, sb_stall_cnt;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .raddr1(raddr1), .raddr2(raddr2), .re1(re1), .re2(re2),
        .id_we(id_we), .id_waddr(id_waddr), .id_lu(id_lu),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_data(ex_data), .ex_dvalid(ex_dvalid),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_data(mem_data), .mem_dvalid(mem_dvalid),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_data(wb_data),
        .lu_done(lu_done), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .src_a(src_a), .src_b(src_b),
        .stall(stall), .id_fire(id_fire), .busy(busy), .deadlock(deadlock),
        .ld_stall_cnt(ld_stall_cnt), .sb_stall_cnt(sb_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_a, fa;
        logic [63:0] sa;
        logic        chk_b, fb;
        logic [63:0] sb;
        logic        stl, fire;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   e_ld = 0, e_sb = 0;
    logic cur_ld = 1'b0, cur_sb = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        id_we = 0; id_waddr = 0; id_lu = 0;
        ex_we = 0; ex_waddr = 0; ex_data = 0; ex_dvalid = 1;
        mem_we = 0; mem_waddr = 0; mem_data = 0; mem_dvalid = 1;
        wb_we = 0; wb_waddr = 0; wb_data = 0;
        lu_done = 0; lu_waddr = 0; lu_wdata = 0;
        cur_ld = 0; cur_sb = 0;
    endtask

    // Inputs already driven; queue the expectation, let comb logic settle, then compare.
    task automatic step(input string tag, input logic ca, input logic fa, input logic [63:0] sa,
                        input logic cb, input logic fb, input logic [63:0] sb,
                        input logic ld, input logic sbk);
        exp_t e;
        cur_ld = ld; cur_sb = sbk;
        e.chk_a = ca; e.fa = fa; e.sa = sa;
        e.chk_b = cb; e.fb = fb; e.sb = sb;
        e.stl = ld | sbk; e.fire = id_valid & ~(ld | sbk);
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        if (e.chk_a) begin
            chk({tag, ".fwd_a"}, 64'(fwd_a), 64'(e.fa));
            chk({tag, ".src_a"}, src_a, e.sa);
        end
        if (e.chk_b) begin
            chk({tag, ".fwd_b"}, 64'(fwd_b), 64'(e.fb));
            chk({tag, ".src_b"}, src_b, e.sb);
        end
        chk({tag, ".stall"}, 64'(stall), 64'(e.stl));
        chk({tag, ".id_fire"}, 64'(id_fire), 64'(e.fire));
    endtask

    task automatic tick();
        if (!rst_n) begin
            e_ld = 0; e_sb = 0;
        end else if (cur_ld) e_ld++;
        else if (cur_sb) e_sb++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, ".ld_cnt"}, 64'(ld_stall_cnt), PERF ? 64'(e_ld) : 64'd0);
        chk({tag, ".sb_cnt"}, 64'(sb_stall_cnt), PERF ? 64'(e_sb) : 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); rst_n = 0;
        tick(); tick();
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.deadlock", 64'(deadlock), 64'd0);
        chk_perf("rst");
        rst_n = 1;
        step("rst.idle", 1, 0, 0, 1, 0, 0, 0, 0);
        tick();

        // EX beats MEM, then MEM, then WB
        id_valid = 1; re1 = 1; raddr1 = 5;
        ex_we = 1; ex_waddr = 5; ex_data = 64'h11;
        mem_we = 1; mem_waddr = 5; mem_data = 64'h22;
        step("ex_pri", 1, 1, 64'h11, 1, 0, 0, 0, 0);
        ex_we = 0;
        step("mem_sel", 1, 1, 64'h22, 0, 0, 0, 0, 0);
        mem_we = 0; wb_we = 1; wb_waddr = 5; wb_data = 64'h33;
        step("wb_sel", 1, 1, 64'h33, 0, 0, 0, 0, 0);
        tick();

        // load-use in EX shadows a valid WB producer
        idle(); id_valid = 1; re2 = 1; raddr2 = 7;
        ex_we = 1; ex_waddr = 7; ex_dvalid = 0; ex_data = 64'h70;
        wb_we = 1; wb_waddr = 7; wb_data = 64'h77;
        step("ld_ex", 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        ex_dvalid = 1;
        step("ld_ex_done", 0, 0, 0, 1, 1, 64'h70, 0, 0);
        tick();
        ex_we = 0; mem_we = 1; mem_waddr = 7; mem_dvalid = 0;
        step("ld_mem", 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk_perf("ld");

        // x0 never forwarded
        idle(); id_valid = 1; re1 = 1; raddr1 = 0;
        ex_we = 1; ex_waddr = 0; ex_data = 64'hDEAD;
        step("x0", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LU issue, scoreboard stall, LU bypass and clear
        idle(); id_valid = 1; id_lu = 1; id_we = 1; id_waddr = 9;
        step("lu_issue9", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("busy9_set", 64'(busy), 64'(32'h1 << 9));
        idle(); id_valid = 1; re1 = 1; raddr1 = 9;
        step("sb_stall9", 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("busy9_hold", 64'(busy), 64'(32'h1 << 9));
        lu_done = 1; lu_waddr = 9; lu_wdata = 64'hAB;
        step("lu_fwd9", 1, 1, 64'hAB, 0, 0, 0, 0, 0);
        tick();
        chk("busy9_clr", 64'(busy), 64'd0);
        chk_perf("sb");

        // set wins over same-cycle clear
        idle(); id_valid = 1; id_lu = 1; id_we = 1; id_waddr = 3;
        step("lu_issue3", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        lu_done = 1; lu_waddr = 3;
        step("set_clr3", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("busy3_setwins", 64'(busy), 64'(32'h1 << 3));
        idle(); lu_done = 1; lu_waddr = 3;
        step("clr3", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("busy3_clr", 64'(busy), 64'd0);

        // WAW against an outstanding LU write, then spurious lu_done
        idle(); id_valid = 1; id_lu = 1; id_we = 1; id_waddr = 4;
        step("lu_issue4", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); id_valid = 1; id_we = 1; id_waddr = 4;
        step("waw4", 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle(); lu_done = 1; lu_waddr = 12; lu_wdata = 64'h12;
        step("lu_spurious", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("busy_spurious", 64'(busy), 64'(32'h1 << 4));

        // LU bypass to a non-busy reg on port B
        idle(); id_valid = 1; re2 = 1; raddr2 = 6; lu_done = 1; lu_waddr = 6; lu_wdata = 64'h66;
        step("lu_fwd6", 0, 0, 0, 1, 1, 64'h66, 0, 0);
        tick();

        // both causes in one cycle count as load-use
        idle(); id_valid = 1; re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 4;
        ex_we = 1; ex_waddr = 7; ex_dvalid = 0;
        step("both", 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        chk_perf("both");

        // deadlock after STALL_LIMIT consecutive stalled cycles
        idle();
        step("pre_dl", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        id_valid = 1; re1 = 1; raddr1 = 4;
        step("dl_stall", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 254; i++) tick();
        chk("dl_254", 64'(deadlock), 64'd0);
        tick();
        chk("dl_255", 64'(deadlock), 64'd1);
        tick(); tick();
        lu_done = 1; lu_waddr = 4; lu_wdata = 64'h44;
        step("dl_release", 1, 1, 64'h44, 0, 0, 0, 0, 0);
        tick();
        chk("dl_sticky", 64'(deadlock), 64'd1);
        chk("busy4_clr", 64'(busy), 64'd0);
        chk_perf("dl");

        // reset in the middle of a scoreboard stall
        idle(); id_valid = 1; id_lu = 1; id_we = 1; id_waddr = 9;
        step("lu_issue9b", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle(); id_valid = 1; re1 = 1; raddr1 = 9;
        step("sb_stall9b", 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst2.busy", 64'(busy), 64'd0);
        chk("rst2.deadlock", 64'(deadlock), 64'd0);
        chk_perf("rst2");
        idle(); lu_done = 1; lu_waddr = 9;
        step("post_rst_lu", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
